// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU divider.
package alu_pkg;
  localparam int ALU_WIDTH = 8;
  localparam int ALU_CNT_W = $clog2(ALU_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_sub_stage.sv
// Combinational WIDTH+1-bit trial subtractor: T = R' + ~{0,D} + 1.
// o_c is the carry-out, high when R' >= D (no borrow).
module alu_sub_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_t,
  output logic             o_c
);
  logic [WIDTH+1:0] w_sum;

  assign w_sum = {1'b0, i_r} + {1'b0, ~{1'b0, i_d}} + {{(WIDTH + 1){1'b0}}, 1'b1};
  assign o_t   = w_sum[WIDTH:0];
  assign o_c   = w_sum[WIDTH+1];
endmodule

// File: rtl/alu_div8_seq.sv
// Sequential restoring divider, one quotient bit per cycle, start/busy/done handshake.
// Optional ALU_DIV_ZERO_TRAP_EN: divide-by-zero short-circuits to DONE and flags div_zero.
module alu_div8_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;
`ifdef ALU_DIV_ZERO_TRAP_EN
  logic             r_bzero;
`endif

  logic [WIDTH:0]   w_rshift;
  logic [WIDTH:0]   w_t;
  logic             w_c;
  logic [WIDTH:0]   w_rnext;
  logic [WIDTH-1:0] w_qnext;
  logic             w_last;

  // Truncating cast drops R's top bit, which is always zero for a restoring divider.
  assign w_rshift = (WIDTH + 1)'({r_rem, r_q[WIDTH-1]});
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  alu_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .i_r (w_rshift),
    .i_d (r_d),
    .o_t (w_t),
    .o_c (w_c)
  );

  // Restore-or-keep selection for one iteration.
  always_comb begin
    w_rnext = w_rshift;
    w_qnext = {r_q[WIDTH-2:0], 1'b0};
    if (w_c) begin
      w_rnext = w_t;
      w_qnext = {r_q[WIDTH-2:0], 1'b1};
    end else begin
      w_rnext = w_rshift;
      w_qnext = {r_q[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= {(WIDTH + 1){1'b0}};
      r_q     <= {WIDTH{1'b0}};
      r_d     <= {WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= {WIDTH{1'b0}};
      r_remo  <= {WIDTH{1'b0}};
      r_dz    <= 1'b0;
`ifdef ALU_DIV_ZERO_TRAP_EN
      r_bzero <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_rem   <= {(WIDTH + 1){1'b0}};
            r_q     <= a;
            r_d     <= b;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
`ifdef ALU_DIV_ZERO_TRAP_EN
            r_bzero <= (b == {WIDTH{1'b0}});
`endif
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
`ifdef ALU_DIV_ZERO_TRAP_EN
          if (r_bzero) begin
            r_quot  <= {WIDTH{1'b1}};
            r_remo  <= r_q;
            r_dz    <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else
`endif
          begin
            r_rem <= w_rnext;
            r_q   <= w_qnext;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_quot  <= w_qnext;
              r_remo  <= w_rnext[WIDTH-1:0];
              r_dz    <= 1'b0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign div_zero  = r_dz;
endmodule

// File: tb/tb_alu_div8_seq.sv
// Self-checking bench for alu_div8_seq: vector table, random ops against an
// arithmetic model, and directed handshake corner cases.
module tb_alu_div8_seq;
`ifdef ALU_DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       busy, done, div_zero;
  logic [7:0] quotient, remainder;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  alu_div8_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap++;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] db);
    return (TRAP && db == 8'd0) ? 1 : 8;
  endfunction

  // Issue a start, return edges from the accepting edge to done (cap 30).
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, output int lat);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] ia, input logic [7:0] ib, input int lat);
    logic [7:0] eq, er;
    eq = (ib == 8'd0) ? 8'hFF : ia / ib;
    er = (ib == 8'd0) ? ia : ia % ib;
    check({tag, " latency"}, lat, exp_lat(ib));
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_zero"}, div_zero, (TRAP && ib == 8'd0) ? 1 : 0);
    check({tag, " busy at done"}, busy, 0);
  endtask

  initial begin
    vec_t vecs[6];
    int lat;
    int dcount;
    logic [7:0] ra, rb;

    vecs[0] = '{8'd200, 8'd7,  8'd28,  8'd4};
    vecs[1] = '{8'd255, 8'd1,  8'd255, 8'd0};
    vecs[2] = '{8'd5,   8'd9,  8'd0,   8'd5};
    vecs[3] = '{8'd77,  8'd0,  8'd255, 8'd77};
    vecs[4] = '{8'd100, 8'd10, 8'd10,  8'd0};
    vecs[5] = '{8'd9,   8'd2,  8'd4,   8'd1};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_zero", div_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors with constant expectations.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check("vec latency", lat, exp_lat(vecs[i].b));
      check("vec quotient", quotient, vecs[i].q);
      check("vec remainder", remainder, vecs[i].r);
      check("vec div_zero", div_zero, (TRAP && vecs[i].b == 8'd0) ? 1 : 0);
      @(posedge clk); #1;
      check("vec done drops", done, 0);
      check("vec quotient held", quotient, vecs[i].q);
      check("vec remainder held", remainder, vecs[i].r);
    end

    // Random operands against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (k % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_op(ra, rb, lat);
      check_result("rand", ra, rb, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Start during RUN is ignored.
    a = 8'd200; b = 8'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("busy after start", busy, 1);
    repeat (2) @(posedge clk);
    #1; a = 8'd1; b = 8'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 3;
    while (!done && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    check_result("ignore start", 8'd200, 8'd7, lat);

    // Reset in the middle of RUN aborts without a done.
    @(posedge clk); #1;
    a = 8'd200; b = 8'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort div_zero", div_zero, 0);
    dcount = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    check("abort no activity", dcount, 0);
    run_op(8'd100, 8'd10, lat);
    check_result("after abort", 8'd100, 8'd10, lat);

    // Back-to-back: start held through the DONE cycle.
    @(posedge clk); #1;
    run_op(8'd200, 8'd7, lat);
    check_result("b2b first", 8'd200, 8'd7, lat);
    a = 8'd9; b = 8'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    check("b2b done spacing", lat, 9);
    check("b2b quotient", quotient, 4);
    check("b2b remainder", remainder, 1);

    check("busy/done overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
